cursor_tracker: RTL and testbench
=================================

// Module: cursor_tracker
// PURPOSE
//  Parametrised paint-cursor position tracker with press-and-hold auto-repeat.
//  Takes level direction buttons (synchronised and debounced upstream).
//  Produces cursor X/Y over a GRID_W x GRID_H canvas plus one extra sidebar
//  column at X==GRID_W. Feeds the pixel writer and the VGA cursor overlay.
//  Adds selectable wrap/clamp edges, hold-delay auto-repeat and a move strobe.
// PARAMETERS
//  GRID_W      32          drawable columns; X legal range 0..GRID_W (GRID_W = sidebar)
//  GRID_H      32          rows; Y legal range 0..GRID_H-1
//  XW          6           userX width; must satisfy 2**XW > GRID_W
//  YW          5           userY width; must satisfy 2**YW >= GRID_H
//  WRAP        1           1 = wrap at edges, 0 = clamp (saturate) at edges
//  HOLD_CYC    25_000_000  cycles a direction is held before first auto-repeat step
//  REPEAT_CYC  5_000_000   cycles between auto-repeat steps
// PORTS
//  CLOCK_50    in   1   system clock
//  reset       in   1   synchronous, active-high reset
//  left        in   1   level, move -X
//  right       in   1   level, move +X
//  up          in   1   level, move -Y
//  down        in   1   level, move +Y
//  userX       out  XW  cursor column, registered
//  userY       out  YW  cursor row, registered
//  moved       out  1   1-cycle pulse, registered with the position change
//  on_sidebar  out  1   combinational, (userX == GRID_W)
// BEHAVIOUR
//  - Reset values:
//    - userX=0, userY=0, moved=0, on_sidebar=0.
//    - FSM=IDLE, timer=0.
//    - Reset has priority over all inputs in every state.
//  - Direction select `dir`: single winner, priority up > down > right > left; none if all low.
//  - FSM states:
//    - IDLE: dir!=none -> step(dir), timer<=HOLD_CYC-1, go HOLD.
//    - HOLD / REPEAT, evaluated in this order:
//      1. dir==none -> IDLE, no step.
//      2. dir differs from the latched dir -> step(new dir), timer<=HOLD_CYC-1, go HOLD.
//      3. timer==0 -> step(dir), timer<=REPEAT_CYC-1, go REPEAT.
//      4. otherwise timer decrements by 1.
//  - Latched dir is updated on every step.
//  - Latency: a press sampled at edge N updates userX/userY and moved at edge N. No extra pipeline.
//  - step(dir) with WRAP=1:
//    - right: X==GRID_W -> 0, else X+1.
//    - left: X==0 -> GRID_W, else X-1.
//    - down: Y==GRID_H-1 -> 0, else Y+1.
//    - up: Y==0 -> GRID_H-1, else Y-1.
//  - step(dir) with WRAP=0: the saturating cases hold the position; moved stays 0.
//  - moved=1 only if userX or userY actually changes; otherwise 0.
//  - Arithmetic is done at XW/YW width. Compare against GRID_W / GRID_H-1, never rely on natural overflow.
//  - Timer width = $clog2(max(HOLD_CYC,REPEAT_CYC)).
//  - Reset mid-hold: next cycle outputs at reset values, FSM=IDLE.
//    - A button still held at reset release counts as a fresh press: immediate step, hold timer restarts.
// CONFIGURATION
//  CURSOR_DIAG_EN defined:
//    - Vertical (up > down) and horizontal (right > left) axes select independently.
//    - A combined step moves both axes in the same cycle.
//    - dir is the {v,h} pair; a change of either component is a direction change.
//    - moved=1 if either axis changes.
//  CURSOR_DIAG_EN undefined:
//    - Single-axis priority as above; simultaneous up+right moves Y only.
// TESTING  (bench params: GRID_W=4, GRID_H=3, HOLD_CYC=4, REPEAT_CYC=2)
//  1. Reset, then five 1-cycle right pulses (gaps between) -> userX 1,2,3,4,0.
//     on_sidebar=1 only at X=4; moved=1 on each step.
//  2. From Y=0, 1-cycle up, WRAP=1 -> userY=2, moved=1.
//     Same with WRAP=0 -> userY=0, moved=0.
//  3. Right held 10 cycles from X=0 -> steps at cycles 0,4,6,8.
//     userX 1,2,3,4; moved high exactly on those cycles.
//  4. Right held 2 cycles, then down held -> immediate Y step on switch cycle.
//     Next Y step 4 cycles later (hold restarted).
//  5. up+right together 1 cycle from (1,1):
//     without CURSOR_DIAG_EN -> (1,0); with it -> (2,0).
//  6. Reset asserted during REPEAT with right held:
//     - next cycle (0,0), moved=0.
//     - on release, X=1 on first cycle; next step 4 cycles later.

Source files
------------

// File: rtl/cursor_tracker.sv
// -----------------------------------------------------------------------------
// cursor_tracker
//   Paint-cursor position tracker with press-and-hold auto-repeat. Direction
//   buttons are level inputs (already synchronised and debounced upstream).
//   The cursor moves over a GRID_W x GRID_H canvas plus one sidebar column at
//   X == GRID_W. Edges either wrap or clamp (WRAP parameter).
//
//   A press steps immediately. Holding the same direction steps again after
//   HOLD_CYC cycles, then every REPEAT_CYC cycles. Changing direction counts
//   as a fresh press.
//
// Ports
//   CLOCK_50    in   system clock
//   reset       in   synchronous, active-high reset (priority over everything)
//   left/right  in   level, move -X / +X
//   up/down     in   level, move -Y / +Y
//   userX       out  cursor column (registered)
//   userY       out  cursor row (registered)
//   moved       out  one-cycle pulse, registered with an actual position change
//   on_sidebar  out  combinational, userX == GRID_W
//
// Configuration macro
//   CURSOR_DIAG_EN  when defined, the vertical (up > down) and horizontal
//                   (right > left) axes select independently and a step can
//                   move both axes at once. When undefined a single direction
//                   wins with priority up > down > right > left.
// -----------------------------------------------------------------------------
module cursor_tracker #(
  parameter int GRID_W     = 32,
  parameter int GRID_H     = 32,
  parameter int XW         = 6,
  parameter int YW         = 5,
  parameter int WRAP       = 1,
  parameter int HOLD_CYC   = 25_000_000,
  parameter int REPEAT_CYC = 5_000_000
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          left,
  input  logic          right,
  input  logic          up,
  input  logic          down,
  output logic [XW-1:0] userX,
  output logic [YW-1:0] userY,
  output logic          moved,
  output logic          on_sidebar
);

  localparam int TMAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [XW-1:0] X_MAX  = XW'(GRID_W);
  localparam logic [YW-1:0] Y_MAX  = YW'(GRID_H - 1);
  localparam logic [XW-1:0] X_ONE  = XW'(1'b1);
  localparam logic [YW-1:0] Y_ONE  = YW'(1'b1);
  localparam logic [TW-1:0] T_ONE  = TW'(1'b1);
  localparam logic [TW-1:0] HOLD_LOAD   = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] REPEAT_LOAD = TW'(REPEAT_CYC - 1);
  localparam bit            WRAP_EN = (WRAP != 0);

  // Per-axis direction codes; the latched direction is the {v,h} pair so the
  // same change detection serves both single-axis and diagonal builds.
  localparam logic [1:0] V_NONE  = 2'd0;
  localparam logic [1:0] V_UP    = 2'd1;
  localparam logic [1:0] V_DOWN  = 2'd2;
  localparam logic [1:0] H_NONE  = 2'd0;
  localparam logic [1:0] H_RIGHT = 2'd1;
  localparam logic [1:0] H_LEFT  = 2'd2;
  localparam logic [3:0] DIR_NONE = 4'd0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  state_t        state_r;
  logic [TW-1:0] timer_r;
  logic [3:0]    last_dir_r;
  logic [XW-1:0] user_x_r;
  logic [YW-1:0] user_y_r;
  logic          moved_r;

  logic [1:0]    v_s;
  logic [1:0]    h_s;
  logic [3:0]    dir_s;
  logic [XW-1:0] step_x_s;
  logic [YW-1:0] step_y_s;
  logic          step_moves_s;

  // Button decode into vertical/horizontal direction codes.
  always_comb begin
    v_s = V_NONE;
    h_s = H_NONE;
`ifdef CURSOR_DIAG_EN
    if (up) begin
      v_s = V_UP;
    end else if (down) begin
      v_s = V_DOWN;
    end else begin
      v_s = V_NONE;
    end
    if (right) begin
      h_s = H_RIGHT;
    end else if (left) begin
      h_s = H_LEFT;
    end else begin
      h_s = H_NONE;
    end
`else
    if (up) begin
      v_s = V_UP;
    end else if (down) begin
      v_s = V_DOWN;
    end else if (right) begin
      h_s = H_RIGHT;
    end else if (left) begin
      h_s = H_LEFT;
    end else begin
      v_s = V_NONE;
      h_s = H_NONE;
    end
`endif
  end

  assign dir_s = {v_s, h_s};

  // Candidate X after a step; edges compared explicitly, no reliance on overflow.
  always_comb begin
    step_x_s = user_x_r;
    case (h_s)
      H_RIGHT: begin
        if (user_x_r == X_MAX) begin
          if (WRAP_EN) begin
            step_x_s = {XW{1'b0}};
          end else begin
            step_x_s = user_x_r;
          end
        end else begin
          step_x_s = user_x_r + X_ONE;
        end
      end
      H_LEFT: begin
        if (user_x_r == {XW{1'b0}}) begin
          if (WRAP_EN) begin
            step_x_s = X_MAX;
          end else begin
            step_x_s = user_x_r;
          end
        end else begin
          step_x_s = user_x_r - X_ONE;
        end
      end
      default: step_x_s = user_x_r;
    endcase
  end

  // Candidate Y after a step.
  always_comb begin
    step_y_s = user_y_r;
    case (v_s)
      V_DOWN: begin
        if (user_y_r == Y_MAX) begin
          if (WRAP_EN) begin
            step_y_s = {YW{1'b0}};
          end else begin
            step_y_s = user_y_r;
          end
        end else begin
          step_y_s = user_y_r + Y_ONE;
        end
      end
      V_UP: begin
        if (user_y_r == {YW{1'b0}}) begin
          if (WRAP_EN) begin
            step_y_s = Y_MAX;
          end else begin
            step_y_s = user_y_r;
          end
        end else begin
          step_y_s = user_y_r - Y_ONE;
        end
      end
      default: step_y_s = user_y_r;
    endcase
  end

  // A clamped step leaves the position untouched and must not pulse moved.
  assign step_moves_s = (step_x_s != user_x_r) || (step_y_s != user_y_r);

  // Press / hold / auto-repeat FSM with registered position and move strobe.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r    <= S_IDLE;
      timer_r    <= {TW{1'b0}};
      last_dir_r <= DIR_NONE;
      user_x_r   <= {XW{1'b0}};
      user_y_r   <= {YW{1'b0}};
      moved_r    <= 1'b0;
    end else begin
      moved_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (dir_s != DIR_NONE) begin
            user_x_r   <= step_x_s;
            user_y_r   <= step_y_s;
            moved_r    <= step_moves_s;
            last_dir_r <= dir_s;
            timer_r    <= HOLD_LOAD;
            state_r    <= S_HOLD;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_HOLD, S_REPEAT: begin
          if (dir_s == DIR_NONE) begin
            state_r <= S_IDLE;
          end else if (dir_s != last_dir_r) begin
            // Switching direction behaves like a fresh press.
            user_x_r   <= step_x_s;
            user_y_r   <= step_y_s;
            moved_r    <= step_moves_s;
            last_dir_r <= dir_s;
            timer_r    <= HOLD_LOAD;
            state_r    <= S_HOLD;
          end else if (timer_r == {TW{1'b0}}) begin
            user_x_r   <= step_x_s;
            user_y_r   <= step_y_s;
            moved_r    <= step_moves_s;
            last_dir_r <= dir_s;
            timer_r    <= REPEAT_LOAD;
            state_r    <= S_REPEAT;
          end else begin
            timer_r <= timer_r - T_ONE;
          end
        end
        default: begin
          state_r <= S_IDLE;
          timer_r <= {TW{1'b0}};
        end
      endcase
    end
  end

  assign userX      = user_x_r;
  assign userY      = user_y_r;
  assign moved      = moved_r;
  assign on_sidebar = (user_x_r == X_MAX);

endmodule

// File: tb/tb_cursor_tracker.sv
module tb_cursor_tracker;

  localparam int GW   = 4;
  localparam int GH   = 3;
  localparam int HOLD = 4;
  localparam int REP  = 2;
`ifdef CURSOR_DIAG_EN
  localparam bit DIAG = 1'b1;
`else
  localparam bit DIAG = 1'b0;
`endif

  logic CLOCK_50 = 1'b0;
  logic reset = 1'b1;
  logic left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0;

  logic [2:0] ux_w, ux_c;
  logic [1:0] uy_w, uy_c;
  logic       mv_w, mv_c, sb_w, sb_c;

  int checks = 0;
  int errors = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  cursor_tracker #(.GRID_W(GW), .GRID_H(GH), .XW(3), .YW(2), .WRAP(1),
                   .HOLD_CYC(HOLD), .REPEAT_CYC(REP)) dut_w (
    .CLOCK_50(CLOCK_50), .reset(reset), .left(left), .right(right),
    .up(up), .down(down), .userX(ux_w), .userY(uy_w), .moved(mv_w),
    .on_sidebar(sb_w));

  cursor_tracker #(.GRID_W(GW), .GRID_H(GH), .XW(3), .YW(2), .WRAP(0),
                   .HOLD_CYC(HOLD), .REPEAT_CYC(REP)) dut_c (
    .CLOCK_50(CLOCK_50), .reset(reset), .left(left), .right(right),
    .up(up), .down(down), .userX(ux_c), .userY(uy_c), .moved(mv_c),
    .on_sidebar(sb_c));

  // ---------------- behavioural reference model ----------------
  // Tracks how long the current direction has been held ("age") and fires a
  // step at age 0, HOLD, HOLD+REP, HOLD+2*REP, ...
  int cur_v, cur_h, new_age;
  bit fire;
  int m_pv = 0, m_ph = 0, m_age = 0;
  int m_xw = 0, m_yw = 0, m_xc = 0, m_yc = 0;
  bit m_mw = 1'b0, m_mc = 1'b0;

  function automatic int wrap_mv(int p, int d, int n);
    return (p + d + n) % n;
  endfunction

  function automatic int clamp_mv(int p, int d, int hi);
    int q;
    q = p + d;
    if (q < 0) q = 0;
    if (q > hi) q = hi;
    return q;
  endfunction

  always_comb begin
    cur_v = 0;
    cur_h = 0;
    if (DIAG) begin
      cur_v = up ? -1 : (down ? 1 : 0);
      cur_h = right ? 1 : (left ? -1 : 0);
    end else if (up) cur_v = -1;
    else if (down) cur_v = 1;
    else if (right) cur_h = 1;
    else if (left) cur_h = -1;
    new_age = (cur_v != m_pv || cur_h != m_ph) ? 0 : m_age + 1;
    fire = (new_age == 0) || (new_age >= HOLD && ((new_age - HOLD) % REP) == 0);
  end

  always @(posedge CLOCK_50) begin
    if (reset) begin
      m_pv <= 0; m_ph <= 0; m_age <= 0;
      m_xw <= 0; m_yw <= 0; m_xc <= 0; m_yc <= 0;
      m_mw <= 1'b0; m_mc <= 1'b0;
    end else if (cur_v == 0 && cur_h == 0) begin
      m_pv <= 0; m_ph <= 0; m_age <= 0;
      m_mw <= 1'b0; m_mc <= 1'b0;
    end else begin
      m_pv <= cur_v; m_ph <= cur_h; m_age <= new_age;
      if (fire) begin
        m_xw <= wrap_mv(m_xw, cur_h, GW + 1);
        m_yw <= wrap_mv(m_yw, cur_v, GH);
        m_xc <= clamp_mv(m_xc, cur_h, GW);
        m_yc <= clamp_mv(m_yc, cur_v, GH - 1);
        m_mw <= (wrap_mv(m_xw, cur_h, GW + 1) != m_xw) || (wrap_mv(m_yw, cur_v, GH) != m_yw);
        m_mc <= (clamp_mv(m_xc, cur_h, GW) != m_xc) || (clamp_mv(m_yc, cur_v, GH - 1) != m_yc);
      end else begin
        m_mw <= 1'b0;
        m_mc <= 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  task automatic set_btn(input logic u, input logic d, input logic l, input logic r);
    up = u; down = d; left = l; right = r;
  endtask

  task automatic do_reset;
    set_btn(0, 0, 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    set_btn(0, 0, 0, 1);
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({ux_w, uy_w, mv_w, sb_w, ux_c, uy_c, mv_c, sb_c} !== 14'd0) begin
      errors++;
      $display("FAIL reset_state got w=(%0d,%0d,m%0b,s%0b) c=(%0d,%0d,m%0b,s%0b) want all 0",
               ux_w, uy_w, mv_w, sb_w, ux_c, uy_c, mv_c, sb_c);
    end
    set_btn(0, 0, 0, 0);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_right_pulses;
    int ex_w, ex_c;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_btn(0, 0, 0, 1);
      tick();
      ex_w = (i + 1) % 5;
      ex_c = (i + 1 > 4) ? 4 : i + 1;
      checks++;
      if (ux_w !== 3'(ex_w) || mv_w !== 1'b1 || sb_w !== (ex_w == 4)) begin
        errors++;
        $display("FAIL pulse_wrap[%0d] got x=%0d m=%0b s=%0b want x=%0d m=1 s=%0b",
                 i, ux_w, mv_w, sb_w, ex_w, (ex_w == 4));
      end
      checks++;
      if (ux_c !== 3'(ex_c) || mv_c !== (i < 4) || sb_c !== (ex_c == 4)) begin
        errors++;
        $display("FAIL pulse_clamp[%0d] got x=%0d m=%0b s=%0b want x=%0d m=%0b s=%0b",
                 i, ux_c, mv_c, sb_c, ex_c, (i < 4), (ex_c == 4));
      end
      set_btn(0, 0, 0, 0);
      tick();
      checks++;
      if (mv_w !== 1'b0 || mv_c !== 1'b0) begin
        errors++;
        $display("FAIL pulse_gap[%0d] got moved w=%0b c=%0b want 0", i, mv_w, mv_c);
      end
    end
  endtask

  task automatic test_up_edge;
    do_reset();
    set_btn(1, 0, 0, 0);
    tick();
    checks++;
    if (uy_w !== 2'd2 || mv_w !== 1'b1) begin
      errors++;
      $display("FAIL up_wrap got y=%0d m=%0b want y=2 m=1", uy_w, mv_w);
    end
    checks++;
    if (uy_c !== 2'd0 || mv_c !== 1'b0) begin
      errors++;
      $display("FAIL up_clamp got y=%0d m=%0b want y=0 m=0", uy_c, mv_c);
    end
    set_btn(0, 0, 0, 0);
    tick();
  endtask

  task automatic test_hold_repeat;
    int steps;
    bit exp_m;
    do_reset();
    steps = 0;
    set_btn(0, 0, 0, 1);
    for (int c = 0; c < 10; c++) begin
      tick();
      exp_m = (c == 0 || c == 4 || c == 6 || c == 8);
      if (exp_m) steps++;
      checks++;
      if (ux_w !== 3'(steps) || mv_w !== exp_m || ux_c !== 3'(steps) || mv_c !== exp_m) begin
        errors++;
        $display("FAIL hold_repeat[c%0d] got w=(x%0d,m%0b) c=(x%0d,m%0b) want x=%0d m=%0b",
                 c, ux_w, mv_w, ux_c, mv_c, steps, exp_m);
      end
    end
    set_btn(0, 0, 0, 0);
    tick();
  endtask

  task automatic test_dir_switch;
    do_reset();
    set_btn(0, 0, 0, 1);
    tick();
    tick();
    set_btn(0, 1, 0, 0);
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (c == 0 && (uy_w !== 2'd1 || mv_w !== 1'b1 || ux_w !== 3'd1)) begin
        errors++;
        $display("FAIL switch_step got (%0d,%0d) m=%0b want (1,1) m=1", ux_w, uy_w, mv_w);
      end else if (c > 0 && c < 4 && (mv_w !== 1'b0 || uy_w !== 2'd1)) begin
        errors++;
        $display("FAIL switch_wait[c%0d] got y=%0d m=%0b want y=1 m=0", c, uy_w, mv_w);
      end else if (c == 4 && (uy_w !== 2'd2 || mv_w !== 1'b1 || uy_c !== 2'd2 || mv_c !== 1'b1)) begin
        errors++;
        $display("FAIL switch_repeat got w=(y%0d,m%0b) c=(y%0d,m%0b) want y=2 m=1",
                 uy_w, mv_w, uy_c, mv_c);
      end
    end
    set_btn(0, 0, 0, 0);
    tick();
  endtask

  task automatic test_diag;
    logic [2:0] ex;
    do_reset();
    set_btn(0, 0, 0, 1); tick();
    set_btn(0, 0, 0, 0); tick();
    set_btn(0, 1, 0, 0); tick();
    set_btn(0, 0, 0, 0); tick();
    set_btn(1, 0, 0, 1);
    tick();
    ex = DIAG ? 3'd2 : 3'd1;
    checks++;
    if (ux_w !== ex || uy_w !== 2'd0 || mv_w !== 1'b1 || ux_c !== ex || uy_c !== 2'd0) begin
      errors++;
      $display("FAIL up_right got w=(%0d,%0d,m%0b) c=(%0d,%0d) want (%0d,0,m1)",
               ux_w, uy_w, mv_w, ux_c, uy_c, ex);
    end
    set_btn(0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset_mid_repeat;
    do_reset();
    set_btn(0, 0, 0, 1);
    for (int c = 0; c < 5; c++) tick();
    checks++;
    if (ux_w !== 3'd2) begin
      errors++;
      $display("FAIL pre_reset_x got %0d want 2", ux_w);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({ux_w, uy_w, mv_w, ux_c, uy_c, mv_c} !== 12'd0) begin
      errors++;
      $display("FAIL mid_reset got w=(%0d,%0d,m%0b) c=(%0d,%0d,m%0b) want (0,0,m0)",
               ux_w, uy_w, mv_w, ux_c, uy_c, mv_c);
    end
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if ((c == 0 && (ux_w !== 3'd1 || mv_w !== 1'b1)) ||
          (c > 0 && c < 4 && (ux_w !== 3'd1 || mv_w !== 1'b0)) ||
          (c == 4 && (ux_w !== 3'd2 || mv_w !== 1'b1))) begin
        errors++;
        $display("FAIL post_reset[c%0d] got x=%0d m=%0b", c, ux_w, mv_w);
      end
    end
    set_btn(0, 0, 0, 0);
    tick();
  endtask

  task automatic test_random;
    logic [6:0] got_w, exp_w, got_c, exp_c;
    logic [3:0] b;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        b = 4'($urandom_range(0, 15));
        set_btn(b[3], b[2], b[1], b[0]);
      end
      reset = ($urandom_range(0, 79) == 0);
      tick();
      got_w = {ux_w, uy_w, mv_w, sb_w};
      exp_w = {3'(m_xw), 2'(m_yw), m_mw, (m_xw == GW)};
      got_c = {ux_c, uy_c, mv_c, sb_c};
      exp_c = {3'(m_xc), 2'(m_yc), m_mc, (m_xc == GW)};
      checks++;
      if (got_w !== exp_w) begin
        errors++;
        $display("FAIL rand_wrap[c%0d] got {x,y,m,s}=%b want %b", c, got_w, exp_w);
      end
      checks++;
      if (got_c !== exp_c) begin
        errors++;
        $display("FAIL rand_clamp[c%0d] got {x,y,m,s}=%b want %b", c, got_c, exp_c);
      end
    end
    reset = 1'b0;
    set_btn(0, 0, 0, 0);
    tick();
  endtask

  initial begin
    @(negedge CLOCK_50);
    test_reset();
    test_right_pulses();
    test_up_edge();
    test_hold_repeat();
    test_dir_switch();
    test_diag();
    test_reset_mid_repeat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
